// File: rtl/mem_port_arbiter_if.sv
// Bundle of the three requester ports, the retire flush and the memory port
// shared by mem_port_arbiter. The slave view is the arbiter; the master view
// is whatever drives the requests and models the memory.
`timescale 1ns/1ps
interface mem_port_arbiter_if;
  // instruction fetch (read)
  logic        fetch_req_i;
  logic [31:0] fetch_addr_i;
  logic        fetch_gnt_o;
  logic        fetch_rvalid_o;
  logic [31:0] fetch_rdata_o;
  // execute-stage load (read)
  logic        load_req_i;
  logic [31:0] load_addr_i;
  logic        load_gnt_o;
  logic        load_rvalid_o;
  logic [31:0] load_rdata_o;
  // retire-stage store (byte-enabled write)
  logic [3:0]  store_we_i;
  logic [31:0] store_addr_i;
  logic [31:0] store_data_i;
  logic        store_gnt_o;
  // pipeline redirect from retire
  logic        flush_i;
  // single-port memory
  logic        mem_en_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  fetch_req_i, fetch_addr_i,
    output fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o,
    input  load_req_i, load_addr_i,
    output load_gnt_o, load_rvalid_o, load_rdata_o,
    input  store_we_i, store_addr_i, store_data_i,
    output store_gnt_o,
    input  flush_i,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output fetch_req_i, fetch_addr_i,
    input  fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o,
    output load_req_i, load_addr_i,
    input  load_gnt_o, load_rvalid_o, load_rdata_o,
    output store_we_i, store_addr_i, store_data_i,
    input  store_gnt_o,
    output flush_i,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for fetch, load and store requesters.
// Fixed priority store > load > fetch, with a starvation override that lets
// fetch win once it has been denied STARVE_LIMIT consecutive cycles. Reads
// occupy the port for READ_LATENCY cycles; the response is steered to the
// requester that issued it, and fetch responses are dropped on a redirect.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int READ_LATENCY = 1,   // 1..7
  parameter int STARVE_LIMIT = 4    // 1..15
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] READ_WAIT = 1'b1;

  localparam logic OWNER_LOAD  = 1'b0;
  localparam logic OWNER_FETCH = 1'b1;

  localparam logic [2:0] LAT_INIT   = 3'(READ_LATENCY);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  // Registered state and its next-state values
  logic [0:0] state_reg,      state_next;
  logic [2:0] lat_cnt_reg,    lat_cnt_next;
  logic [3:0] starve_cnt_reg, starve_cnt_next;
  logic       owner_reg,      owner_next;
  logic       cancel_reg,     cancel_next;

  // Combinational arbitration results
  logic store_req;
  logic in_idle;
  logic fetch_starved;
  logic store_gnt;
  logic load_gnt;
  logic fetch_gnt;
  logic read_gnt;

  // Response path
  logic data_cycle;
  logic load_rvalid;
  logic fetch_rvalid;

  // Memory port drive
  logic [31:0] wdata_mux;
  logic [31:0] addr_mux;

  // Grant decision: one winner per IDLE cycle, all grants forced low in reset
  always_comb begin
    store_req     = |bus.store_we_i;
    in_idle       = !reset && (state_reg == IDLE);
    fetch_starved = bus.fetch_req_i && (starve_cnt_reg == STARVE_MAX);
    store_gnt     = in_idle && store_req && !fetch_starved;
    load_gnt      = in_idle && bus.load_req_i && !store_req && !fetch_starved;
    fetch_gnt     = in_idle && bus.fetch_req_i &&
                    (fetch_starved || (!store_req && !bus.load_req_i));
    read_gnt      = load_gnt || fetch_gnt;
  end

  // Address select for whichever requester owns the port this cycle
  always_comb begin
    addr_mux = 32'h0;
    if (store_gnt) begin
      addr_mux = bus.store_addr_i;
    end else if (load_gnt) begin
      addr_mux = bus.load_addr_i;
    end else if (fetch_gnt) begin
      addr_mux = bus.fetch_addr_i;
    end
  end

  // Write data lanes: the full word is presented on a store, zero otherwise;
  // the byte enables decide which lanes the memory actually commits.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_wdata_lane
      assign wdata_mux[8*gi +: 8] = store_gnt ? bus.store_data_i[8*gi +: 8] : 8'h00;
    end
  endgenerate

  assign bus.store_gnt_o = store_gnt;
  assign bus.load_gnt_o  = load_gnt;
  assign bus.fetch_gnt_o = fetch_gnt;
  assign bus.mem_en_o    = store_gnt || read_gnt;
  assign bus.mem_we_o    = store_gnt ? bus.store_we_i : 4'b0000;
  assign bus.mem_addr_o  = addr_mux;
  assign bus.mem_wdata_o = wdata_mux;

  // Response steering: the last READ_WAIT cycle carries the memory data.
  // A flush landing on the data cycle itself still kills the fetch pulse.
  always_comb begin
    data_cycle   = !reset && (state_reg == READ_WAIT) && (lat_cnt_reg == 3'd1);
    load_rvalid  = data_cycle && (owner_reg == OWNER_LOAD);
    fetch_rvalid = data_cycle && (owner_reg == OWNER_FETCH) &&
                   !cancel_reg && !bus.flush_i;
  end

  assign bus.load_rvalid_o  = load_rvalid;
  assign bus.load_rdata_o   = load_rvalid  ? bus.mem_rdata_i : 32'h0;
  assign bus.fetch_rvalid_o = fetch_rvalid;
  assign bus.fetch_rdata_o  = fetch_rvalid ? bus.mem_rdata_i : 32'h0;

  // FSM next state: launch reads from IDLE, count down the memory latency
  always_comb begin
    state_next   = state_reg;
    lat_cnt_next = lat_cnt_reg;
    owner_next   = owner_reg;
    cancel_next  = cancel_reg;
    case (state_reg)
      IDLE: begin
        if (read_gnt) begin
          state_next   = READ_WAIT;
          lat_cnt_next = LAT_INIT;
          owner_next   = fetch_gnt ? OWNER_FETCH : OWNER_LOAD;
          cancel_next  = fetch_gnt && bus.flush_i;
        end
      end
      READ_WAIT: begin
        if (lat_cnt_reg == 3'd1) begin
          // memory cannot abort, so a cancelled fetch still runs to here
          state_next   = IDLE;
          lat_cnt_next = 3'd0;
          cancel_next  = 1'b0;
        end else begin
          lat_cnt_next = lat_cnt_reg - 3'd1;
          if ((owner_reg == OWNER_FETCH) && bus.flush_i) begin
            cancel_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Starvation counter: counts consecutive denied fetch cycles, saturating
  always_comb begin
    starve_cnt_next = 4'd0;
    if (bus.fetch_req_i && !fetch_gnt) begin
      starve_cnt_next = (starve_cnt_reg == STARVE_MAX) ? STARVE_MAX
                                                       : starve_cnt_reg + 4'd1;
    end
  end

  // State registers with synchronous reset; reset drops any pending response
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      lat_cnt_reg    <= 3'd0;
      starve_cnt_reg <= 4'd0;
      owner_reg      <= OWNER_LOAD;
      cancel_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      lat_cnt_reg    <= lat_cnt_next;
      starve_cnt_reg <= starve_cnt_next;
      owner_reg      <= owner_next;
      cancel_reg     <= cancel_next;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a latency-pipelined memory responder, a
// cycle-timestamp reference model compared on every negedge, and directed
// scenarios with hand-computed literal expectations.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int RL = 3;
  localparam int SL = 4;

  logic clk = 1'b0;
  logic reset;

  mem_port_arbiter_if bus();

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .READ_LATENCY(RL),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] init_word(input int i);
    return (i == 'h40) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(i);
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // ---------------- memory responder (behaves like the real RAM) ----------
  logic [31:0] rmem [256];
  logic [31:0] pipe_d [RL];
  logic        pipe_v [RL];
  bit          mem_loaded;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) rmem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end
    for (int i = RL - 1; i > 0; i--) begin
      pipe_d[i] <= pipe_d[i-1];
      pipe_v[i] <= pipe_v[i-1];
    end
    pipe_v[0] <= bus.mem_en_o && (bus.mem_we_o == 4'b0000);
    pipe_d[0] <= rmem[bus.mem_addr_o[9:2]];
    if (bus.mem_en_o) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_we_o[b]) rmem[bus.mem_addr_o[9:2]][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
      end
    end
  end

  assign bus.mem_rdata_i = (pipe_v[RL-1] === 1'b1) ? pipe_d[RL-1] : 32'hBAD0_BAD0;

  // ---------------- reference model ---------------------------------------
  // Tracks the port as "busy until cycle pend_due" and computes outputs
  // directly from the priority and starvation rules.
  logic [31:0] mmem [256];
  bit          pend, pend_fetch, pend_cancel;
  int          pend_due;
  logic [31:0] pend_addr;
  int          starve;
  int          cyc;
  bit          e_fg, e_lg, e_sg, e_frv, e_lrv, e_en;
  logic [3:0]  e_we;
  logic [31:0] e_frd, e_lrd, e_addr, e_wd;

  task model_eval();
    e_fg = 0; e_lg = 0; e_sg = 0; e_frv = 0; e_lrv = 0; e_en = 0;
    e_we = 4'b0; e_frd = 32'h0; e_lrd = 32'h0; e_addr = 32'h0; e_wd = 32'h0;
    if (reset !== 1'b1) begin
      if (pend) begin
        if (cyc == pend_due) begin
          if (pend_fetch) begin
            if (!pend_cancel && !bus.flush_i) begin
              e_frv = 1;
              e_frd = mmem[pend_addr[9:2]];
            end
          end else begin
            e_lrv = 1;
            e_lrd = mmem[pend_addr[9:2]];
          end
        end
      end else begin
        if (bus.fetch_req_i && starve >= SL) e_fg = 1;
        else if (bus.store_we_i != 4'b0) e_sg = 1;
        else if (bus.load_req_i) e_lg = 1;
        else if (bus.fetch_req_i) e_fg = 1;
        if (e_sg) begin
          e_en = 1; e_we = bus.store_we_i; e_addr = bus.store_addr_i; e_wd = bus.store_data_i;
        end else if (e_lg) begin
          e_en = 1; e_addr = bus.load_addr_i;
        end else if (e_fg) begin
          e_en = 1; e_addr = bus.fetch_addr_i;
        end
      end
    end
  endtask

  task model_update();
    if (reset === 1'b1) begin
      pend = 0; pend_cancel = 0; starve = 0;
    end else begin
      if (pend && pend_fetch && bus.flush_i) pend_cancel = 1;
      if (pend && cyc == pend_due) pend = 0;
      if (e_lg || e_fg) begin
        pend = 1; pend_due = cyc + RL; pend_fetch = e_fg;
        pend_cancel = e_fg && bus.flush_i; pend_addr = e_addr;
      end
      if (e_sg) begin
        for (int b = 0; b < 4; b++) begin
          if (e_we[b]) mmem[e_addr[9:2]][8*b +: 8] = e_wd[8*b +: 8];
        end
      end
      if (bus.fetch_req_i && !e_fg) starve = (starve < SL) ? starve + 1 : SL;
      else starve = 0;
    end
    cyc++;
  endtask

  // Compare process: model updated on posedge, outputs checked on negedge
  initial begin : model_proc
    for (int i = 0; i < 256; i++) mmem[i] = init_word(i);
    cyc = 0; starve = 0; pend = 0;
    forever begin
      @(posedge clk);
      model_update();
      @(negedge clk);
      model_eval();
      chk1 ("mdl_fetch_gnt",    bus.fetch_gnt_o,    e_fg);
      chk1 ("mdl_load_gnt",     bus.load_gnt_o,     e_lg);
      chk1 ("mdl_store_gnt",    bus.store_gnt_o,    e_sg);
      chk1 ("mdl_fetch_rvalid", bus.fetch_rvalid_o, e_frv);
      chk32("mdl_fetch_rdata",  bus.fetch_rdata_o,  e_frd);
      chk1 ("mdl_load_rvalid",  bus.load_rvalid_o,  e_lrv);
      chk32("mdl_load_rdata",   bus.load_rdata_o,   e_lrd);
      chk1 ("mdl_mem_en",       bus.mem_en_o,       e_en);
      chk32("mdl_mem_we",       32'(bus.mem_we_o),  32'(e_we));
      chk32("mdl_mem_addr",     bus.mem_addr_o,     e_addr);
      chk32("mdl_mem_wdata",    bus.mem_wdata_o,    e_wd);
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus -------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin : stim
    reset = 1'b1;
    bus.fetch_req_i = 0; bus.fetch_addr_i = 0;
    bus.load_req_i = 0;  bus.load_addr_i = 0;
    bus.store_we_i = 0;  bus.store_addr_i = 0; bus.store_data_i = 0;
    bus.flush_i = 0;
    step(); step();
    // reset: a request present must not produce a grant or memory access
    bus.fetch_req_i = 1; bus.fetch_addr_i = 32'h100; settle();
    chk1("lit_rst_fetch_gnt", bus.fetch_gnt_o, 1'b0);
    chk1("lit_rst_mem_en", bus.mem_en_o, 1'b0);
    chk32("lit_rst_mem_addr", bus.mem_addr_o, 32'h0);

    // A: fetch read, then a load that arrived during READ_WAIT
    step(); reset = 0; settle();
    chk1("lit_a_fetch_gnt", bus.fetch_gnt_o, 1'b1);
    chk32("lit_a_mem_addr", bus.mem_addr_o, 32'h100);
    step(); bus.fetch_req_i = 0; bus.load_req_i = 1; bus.load_addr_i = 32'h104; settle();
    chk1("lit_a_load_wait", bus.load_gnt_o, 1'b0);
    step();
    step(); settle();
    chk1("lit_a_fetch_rvalid", bus.fetch_rvalid_o, 1'b1);
    chk32("lit_a_fetch_rdata", bus.fetch_rdata_o, 32'hDEADBEEF);
    step(); settle();
    chk1("lit_a_load_gnt", bus.load_gnt_o, 1'b1);
    step(); bus.load_req_i = 0;
    step();
    step(); settle();
    chk32("lit_a_load_rdata", bus.load_rdata_o, 32'h10000041);
    step();

    // B: store, load and fetch together
    step();
    bus.store_we_i = 4'b0011; bus.store_addr_i = 32'h200; bus.store_data_i = 32'h1234;
    bus.load_req_i = 1; bus.load_addr_i = 32'h200;
    bus.fetch_req_i = 1; bus.fetch_addr_i = 32'h104; settle();
    chk1("lit_b_store_gnt", bus.store_gnt_o, 1'b1);
    chk32("lit_b_mem_we", 32'(bus.mem_we_o), 32'h3);
    chk32("lit_b_mem_wdata", bus.mem_wdata_o, 32'h1234);
    step(); bus.store_we_i = 0; settle();
    chk1("lit_b_load_gnt", bus.load_gnt_o, 1'b1);
    step(); bus.load_req_i = 0;
    step();
    step(); settle();
    chk32("lit_b_load_rdata", bus.load_rdata_o, 32'h10001234);
    step(); settle();
    chk1("lit_b_fetch_gnt", bus.fetch_gnt_o, 1'b1);
    step(); bus.fetch_req_i = 0;
    step();
    step(); settle();
    chk32("lit_b_fetch_rdata", bus.fetch_rdata_o, 32'h10000041);
    step();

    // C: starvation override while load is held continuously
    step();
    bus.load_req_i = 1; bus.load_addr_i = 32'h300;
    bus.fetch_req_i = 1; bus.fetch_addr_i = 32'h108; settle();
    chk1("lit_c_load_gnt0", bus.load_gnt_o, 1'b1);
    step(); step();
    step(); settle();
    chk32("lit_c_load_rdata", bus.load_rdata_o, 32'h100000C0);
    step(); settle();
    chk1("lit_c_fetch_starved_gnt", bus.fetch_gnt_o, 1'b1);
    chk1("lit_c_load_denied", bus.load_gnt_o, 1'b0);
    step(); bus.fetch_req_i = 0;
    step();
    step(); settle();
    chk32("lit_c_fetch_rdata", bus.fetch_rdata_o, 32'h10000042);
    step(); settle();
    chk1("lit_c_load_gnt1", bus.load_gnt_o, 1'b1);
    step(); bus.load_req_i = 0;
    step(); step(); step();

    // D: flush mid-read cancels fetch response; pending load granted after
    step(); bus.fetch_req_i = 1; bus.fetch_addr_i = 32'h10C; settle();
    chk1("lit_d_fetch_gnt", bus.fetch_gnt_o, 1'b1);
    step(); bus.fetch_req_i = 0; bus.load_req_i = 1; bus.load_addr_i = 32'h104;
    step(); bus.flush_i = 1;
    step(); bus.flush_i = 0; settle();
    chk1("lit_d_fetch_rvalid", bus.fetch_rvalid_o, 1'b0);
    chk32("lit_d_fetch_rdata", bus.fetch_rdata_o, 32'h0);
    step(); settle();
    chk1("lit_d_load_gnt", bus.load_gnt_o, 1'b1);
    step(); bus.load_req_i = 0;
    step(); step(); step();

    // E: flush in idle is harmless; flush on the data cycle kills the pulse
    step(); bus.flush_i = 1;
    step(); bus.flush_i = 0; bus.fetch_req_i = 1; bus.fetch_addr_i = 32'h100; settle();
    chk1("lit_e_fetch_gnt", bus.fetch_gnt_o, 1'b1);
    step(); bus.fetch_req_i = 0;
    step();
    step(); bus.flush_i = 1; settle();
    chk1("lit_e_data_cycle_flush", bus.fetch_rvalid_o, 1'b0);
    step(); bus.flush_i = 0;
    // flush in the grant cycle
    step(); bus.fetch_req_i = 1; bus.fetch_addr_i = 32'h100; bus.flush_i = 1;
    step(); bus.fetch_req_i = 0; bus.flush_i = 0;
    step();
    step(); settle();
    chk1("lit_e_grant_flush", bus.fetch_rvalid_o, 1'b0);
    step();

    // F: flush has no effect on loads
    step(); bus.load_req_i = 1; bus.load_addr_i = 32'h100; bus.flush_i = 1; settle();
    chk1("lit_f_load_gnt", bus.load_gnt_o, 1'b1);
    step(); bus.load_req_i = 0;
    step();
    step(); settle();
    chk1("lit_f_load_rvalid", bus.load_rvalid_o, 1'b1);
    chk32("lit_f_load_rdata", bus.load_rdata_o, 32'hDEADBEEF);
    step(); bus.flush_i = 0;

    // G: reset during READ_WAIT discards the load response
    step(); bus.load_req_i = 1; bus.load_addr_i = 32'h104; settle();
    chk1("lit_g_load_gnt", bus.load_gnt_o, 1'b1);
    step(); bus.load_req_i = 0; reset = 1; settle();
    chk1("lit_g_rst_load_rvalid", bus.load_rvalid_o, 1'b0);
    chk1("lit_g_rst_mem_en", bus.mem_en_o, 1'b0);
    step(); reset = 0; bus.fetch_req_i = 1; bus.fetch_addr_i = 32'h100; settle();
    chk1("lit_g_fetch_gnt", bus.fetch_gnt_o, 1'b1);
    step(); bus.fetch_req_i = 0; settle();
    chk1("lit_g_no_load_rvalid", bus.load_rvalid_o, 1'b0);
    chk32("lit_g_no_load_rdata", bus.load_rdata_o, 32'h0);
    step();
    step(); settle();
    chk32("lit_g_fetch_rdata", bus.fetch_rdata_o, 32'hDEADBEEF);
    step();

    // H: back-to-back stores then readback
    step(); bus.store_we_i = 4'b1111; bus.store_addr_i = 32'h204; bus.store_data_i = 32'hCAFEF00D; settle();
    chk1("lit_h_store0_gnt", bus.store_gnt_o, 1'b1);
    step(); bus.store_we_i = 4'b1000; bus.store_data_i = 32'h55000000; settle();
    chk1("lit_h_store1_gnt", bus.store_gnt_o, 1'b1);
    step(); bus.store_we_i = 0; bus.load_req_i = 1; bus.load_addr_i = 32'h204; settle();
    chk1("lit_h_load_gnt", bus.load_gnt_o, 1'b1);
    step(); bus.load_req_i = 0;
    step();
    step(); settle();
    chk32("lit_h_load_rdata", bus.load_rdata_o, 32'h55FEF00D);
    step(); step();

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
